dpd_digit_streamer: RTL and testbench
=====================================

Name: dpd_digit_streamer

Overview:
Reader-side counterpart to the team's declet packer. It accepts a stream of 10-bit densely-packed-decimal (DPD) declets over a valid/ready handshake and buffers them. Each declet is unpacked into three BCD digits, which are emitted serially, most significant first, on a second valid/ready handshake. Optional per-frame leading-zero suppression is supported. It sits between a byte/declet deserializer and a BCD display or serial-digit consumer.

Parameters:
FIFO_DEPTH, 2, declet buffer entries; power of 2, >=2.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  declet offered
in_ready  output  1  block can accept a declet this cycle
in_declet  input  10  DPD declet, bits b9..b0 = p q r s t u v w x y
in_last  input  1  declet is the final declet of a frame
in_lz  input  1  suppress leading zeros for the frame this declet belongs to
out_valid  output  1  out_digit valid
out_ready  input  1  consumer accepts digit
out_digit  output  4  BCD digit 0..9
out_last  output  1  digit is the final digit of a frame

Behaviour:
- Reset, synchronous active-low (rst_n sampled on clk): FIFO empty, unpack stage empty, lead flag = 1, out_valid = 0, out_digit = 0, out_last = 0. in_valid is ignored on reset edges. A reset mid-frame discards all buffered declets and partial digits; no out_last is emitted for the lost frame.
- Input handshake: transfer when in_valid && in_ready. in_ready = !fifo_full (combinational from count). Each FIFO entry stores {in_lz, in_last, in_declet}.
- Unpack stage: holds 3 digits (d2, d1, d0), a 2-bit index, last and lz flags.
  - It loads from the FIFO head when it is empty, or on the same edge its final digit is consumed or skipped, so there are no bubbles between declets.
- Latency: a declet accepted in cycle C into an empty block gives out_valid = 1 in cycle C+2, with out_digit = d2.
- DPD decode, combinational on FIFO head:
  - v=0: d2=0pqr, d1=0stu, d0=0wxy.
  - v=1, wx=00: 0pqr, 0stu, 100y.
  - wx=01: 0pqr, 100u, 0sty.
  - wx=10: 100r, 0stu, 0pqy.
  - wx=11, st=00: 100r, 100u, 0pqy.
  - wx=11, st=01: 100r, 0pqu, 100y.
  - wx=11, st=10: 0pqr, 100u, 100y.
  - wx=11, st=11: 100r, 100u, 100y; p and q are ignored.
  - All 1024 codes decode to digits 0..9, so there is no error output.
- Output handshake:
  - A digit transfers when out_valid && out_ready.
  - out_digit and out_last hold stable while out_valid && !out_ready.
  - Digit order is d2, d1, d0.
- out_last = 1 only with d0 of a declet flagged last.
- Leading-zero suppression, when the entry's lz = 1 and lead = 1:
  - A zero digit is skipped: it is consumed internally in one cycle with out_valid = 0.
  - Exception: d0 of a last declet is always emitted, so an all-zero frame yields a single 0 with out_last = 1.
- lead flag clears on the first emitted digit. It sets again after out_last transfers, or on reset.
- With lz = 0, all three digits are emitted regardless of lead.
- Throughput: 1 digit per cycle sustained when out_ready = 1 and the FIFO is non-empty.
- Capacity: FIFO_DEPTH declets plus 1 in the unpack stage.
- Simultaneous FIFO push and pop when full: not allowed, because in_ready = 0. Push and pop in the same cycle otherwise keeps the count.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. in_declet=10'h3FF, last=1, lz=0, out_ready=1 -> digits 9,9,9; out_last only on the third; first out_valid 2 cycles after accept.
2. in_declet=10'h07B, last=1, lz=1 -> digits 9,7 only; one bubble cycle before the 9; out_last on the 7. Same declet with lz=0 -> 0,9,7.
3. Frame of declets 10'h000 (last=0) then 10'h000 (last=1), lz=1 -> exactly one digit 0 with out_last=1. Next frame 10'h001 with lz=1 -> digit 1 (lead restored).
4. out_ready=0 while 4 declets are offered -> 3 accepted, in_ready=0 afterwards; out_digit holds 9 stable. Release out_ready -> all 9 digits in order, in_ready reasserts after the first declet pops.
5. Reset asserted after 1 digit of a 2-declet frame -> out_valid=0 and in_ready=1 the cycle after reset; no stale digits appear. A new lz=1 frame suppresses leading zeros.
6. Exhaustive sweep of all 1024 declets, lz=0, continuous valid/ready -> digits match a reference DPD decoder; one digit per cycle with no bubbles.

Source files
------------

// File: rtl/dpd_digit_streamer_if.sv
// dpd_digit_streamer_if
//   Groups the declet input channel and the BCD digit output channel of
//   dpd_digit_streamer.
//   master : environment side (drives declets, accepts digits)
//   slave  : streamer side (accepts declets, drives digits)
//   in_valid/in_ready/in_declet/in_last/in_lz : declet channel
//   out_valid/out_ready/out_digit/out_last    : digit channel
interface dpd_digit_streamer_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_declet;
  logic       in_last;
  logic       in_lz;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_last;

  modport master (
    output in_valid, in_declet, in_last, in_lz, out_ready,
    input  in_ready, out_valid, out_digit, out_last
  );

  modport slave (
    input  in_valid, in_declet, in_last, in_lz, out_ready,
    output in_ready, out_valid, out_digit, out_last
  );
endinterface

// File: rtl/dpd_digit_streamer.sv
// dpd_digit_streamer
//   Buffers 10-bit DPD declets in a small FIFO, unpacks each into three BCD
//   digits and streams them out most significant first, with optional
//   per-frame leading-zero suppression.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of dpd_digit_streamer_if (declet in, digit out)
module dpd_digit_streamer #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  dpd_digit_streamer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Unpack stage: empty, or presenting one of the three digits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_D2    = 2'd1,
    ST_D1    = 2'd2,
    ST_D0    = 2'd3
  } stage_t;

  // DPD declet {p,q,r,s,t,u,v,w,x,y} -> {d2,d1,d0}. Every code is legal.
  function automatic logic [11:0] dpd_decode(input logic [9:0] code);
    logic p, q, r, s, t, u, v, w, x, y;
    logic [11:0] d;
    {p, q, r, s, t, u, v, w, x, y} = code;
    d = 12'h000;
    casez ({v, w, x, s, t})
      5'b0????: d = {1'b0, p, q, r, 1'b0, s, t, u, 1'b0, w, x, y};
      5'b100??: d = {1'b0, p, q, r, 1'b0, s, t, u, 3'b100, y};
      5'b101??: d = {1'b0, p, q, r, 3'b100, u, 1'b0, s, t, y};
      5'b110??: d = {3'b100, r, 1'b0, s, t, u, 1'b0, p, q, y};
      5'b11100: d = {3'b100, r, 3'b100, u, 1'b0, p, q, y};
      5'b11101: d = {3'b100, r, 1'b0, p, q, u, 3'b100, y};
      5'b11110: d = {1'b0, p, q, r, 3'b100, u, 3'b100, y};
      5'b11111: d = {3'b100, r, 3'b100, u, 3'b100, y};
      default:  d = 12'h000;
    endcase
    return d;
  endfunction

  // Digit currently presented by a stage state.
  function automatic logic [3:0] select_digit(input stage_t st, input logic [3:0] d2,
                                              input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] dig;
    case (st)
      ST_D2:   dig = d2;
      ST_D1:   dig = d1;
      ST_D0:   dig = d0;
      default: dig = 4'd0;
    endcase
    return dig;
  endfunction

  // A presented zero is swallowed while still leading in an lz frame,
  // except the final digit of the frame so an all-zero frame still shows 0.
  function automatic logic suppress(input stage_t st, input logic lz, input logic lead,
                                    input logic [3:0] dig, input logic last);
    return (st != ST_EMPTY) && lz && lead && (dig == 4'd0) && !((st == ST_D0) && last);
  endfunction

  // ---------------- declet FIFO: {lz, last, declet} ----------------
  logic [11:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [11:0]   head_s;

  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign bus.in_ready = (count_r != FULL_COUNT);
  assign push_s       = bus.in_valid && bus.in_ready;
  assign head_s       = mem_r[rd_ptr_r];

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 12'h000;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.in_lz, bus.in_last, bus.in_declet};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // ---------------- unpack stage ----------------
  stage_t     state_r, state_nxt_s;
  logic [3:0] d2_r, d1_r, d0_r;
  logic [3:0] d2_nxt_s, d1_nxt_s, d0_nxt_s;
  logic       last_r, last_nxt_s;
  logic       lz_r, lz_nxt_s;
  logic       lead_r, lead_nxt_s;
  logic       out_valid_r, out_valid_nxt_s;
  logic [3:0] out_digit_r, out_digit_nxt_s;
  logic       out_last_r, out_last_nxt_s;
  logic       skip_s, fire_s, advance_s, done_s;

  assign skip_s    = suppress(state_r, lz_r, lead_r,
                              select_digit(state_r, d2_r, d1_r, d0_r), last_r);
  assign fire_s    = out_valid_r && bus.out_ready;
  assign advance_s = fire_s || skip_s;
  assign done_s    = advance_s && (state_r == ST_D0);
  // Refill as the final digit leaves so consecutive declets run back to back.
  assign pop_s     = !fifo_empty_s && ((state_r == ST_EMPTY) || done_s);

  // Next stage contents and lead flag.
  always_comb begin
    state_nxt_s = state_r;
    d2_nxt_s    = d2_r;
    d1_nxt_s    = d1_r;
    d0_nxt_s    = d0_r;
    last_nxt_s  = last_r;
    lz_nxt_s    = lz_r;
    lead_nxt_s  = lead_r;
    if (pop_s) begin
      state_nxt_s                      = ST_D2;
      {d2_nxt_s, d1_nxt_s, d0_nxt_s}   = dpd_decode(head_s[9:0]);
      last_nxt_s                       = head_s[10];
      lz_nxt_s                         = head_s[11];
    end else if (done_s) begin
      state_nxt_s = ST_EMPTY;
    end else if (advance_s) begin
      case (state_r)
        ST_D2:   state_nxt_s = ST_D1;
        ST_D1:   state_nxt_s = ST_D0;
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    if (fire_s && out_last_r) begin
      lead_nxt_s = 1'b1;
    end else if (fire_s) begin
      lead_nxt_s = 1'b0;
    end else begin
      lead_nxt_s = lead_r;
    end
  end

  // Output values derived from the next stage contents, so they can be registered.
  always_comb begin
    out_digit_nxt_s = select_digit(state_nxt_s, d2_nxt_s, d1_nxt_s, d0_nxt_s);
    out_valid_nxt_s = (state_nxt_s != ST_EMPTY) &&
                      !suppress(state_nxt_s, lz_nxt_s, lead_nxt_s, out_digit_nxt_s, last_nxt_s);
    out_last_nxt_s  = (state_nxt_s == ST_D0) && last_nxt_s;
  end

  // Stage state register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      d2_r        <= 4'd0;
      d1_r        <= 4'd0;
      d0_r        <= 4'd0;
      last_r      <= 1'b0;
      lz_r        <= 1'b0;
      lead_r      <= 1'b1;
      out_valid_r <= 1'b0;
      out_digit_r <= 4'd0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      d2_r        <= d2_nxt_s;
      d1_r        <= d1_nxt_s;
      d0_r        <= d0_nxt_s;
      last_r      <= last_nxt_s;
      lz_r        <= lz_nxt_s;
      lead_r      <= lead_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_digit_r <= out_digit_nxt_s;
      out_last_r  <= out_last_nxt_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_digit = out_digit_r;
  assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_dpd_digit_streamer.sv
// tb_dpd_digit_streamer
//   Directed and randomized stimulus for dpd_digit_streamer. Expected digits
//   come from a frame-level reference: a BCD->DPD encoder builds a decode
//   table, and each frame's digit string is trimmed of leading zeros when lz.
module tb_dpd_digit_streamer;
  logic clk = 1'b0;
  logic rst_n;

  dpd_digit_streamer_if bus ();

  dpd_digit_streamer #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lz;
    logic       last;
    logic [9:0] d;
  } ent_t;

  ent_t        in_q [$];
  logic [4:0]  exp_q [$];   // {last, digit}
  logic [3:0]  pend_q [$];  // digits of the frame being assembled
  logic [11:0] ref_tab [1024];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Standard BCD triple -> DPD declet {p,q,r,s,t,u,v,w,x,y}.
  function automatic logic [9:0] ref_encode(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [9:0] e;
    case ({a[3], b[3], c[3]})
      3'b000:  e = {a[2:0], b[2:0], 1'b0, c[2:0]};
      3'b001:  e = {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
      3'b010:  e = {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
      3'b100:  e = {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
      3'b110:  e = {c[2:1], a[0], 2'b00, b[0], 3'b111, c[0]};
      3'b101:  e = {b[2:1], a[0], 2'b01, b[0], 3'b111, c[0]};
      3'b011:  e = {a[2:0], 2'b10, b[0], 3'b111, c[0]};
      default: e = {2'b00, a[0], 2'b11, b[0], 3'b111, c[0]};
    endcase
    return e;
  endfunction

  // Non-canonical codes (all three digits large) ignore p and q.
  function automatic logic [11:0] ref_digits(input logic [9:0] code);
    logic [9:0] k;
    k = code;
    if (k[3:1] == 3'b111 && k[6:5] == 2'b11) k[9:8] = 2'b00;
    return ref_tab[k];
  endfunction

  task automatic add_declet(input logic [9:0] d, input logic last, input logic lz);
    logic [11:0] dg;
    int first;
    ent_t en;
    en.lz = lz; en.last = last; en.d = d;
    in_q.push_back(en);
    dg = ref_digits(d);
    pend_q.push_back(dg[11:8]);
    pend_q.push_back(dg[7:4]);
    pend_q.push_back(dg[3:0]);
    if (last) begin
      first = 0;
      if (lz) begin
        while (first < pend_q.size() - 1 && pend_q[first] == 4'd0) first++;
      end
      for (int i = first; i < pend_q.size(); i++) begin
        exp_q.push_back({(i == pend_q.size() - 1), pend_q[i]});
      end
      pend_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_declet = 10'h000;
    bus.in_last   = 1'b0;
    bus.in_lz     = 1'b0;
  endtask

  // Offer one declet until taken (bounded); returns just after the accepting edge.
  task automatic push_one(input logic [9:0] d, input logic last, input logic lz);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_declet = d;
    bus.in_last   = last;
    bus.in_lz     = lz;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("push_ready", bus.in_ready, 1);
    tick();
    idle();
  endtask

  // Drain in_q into the DUT and check every transferred digit against exp_q.
  task automatic run_engine(input int vprob, input int rprob, input bit strict, input int budget);
    int   cyc = 0;
    bit   started = 1'b0;
    bit   acc;
    logic [4:0] e;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      bus.in_valid = (in_q.size() > 0) && ($urandom_range(99) < vprob);
      if (in_q.size() > 0) {bus.in_lz, bus.in_last, bus.in_declet} = in_q[0];
      else {bus.in_lz, bus.in_last, bus.in_declet} = 12'h000;
      bus.out_ready = ($urandom_range(99) < rprob);
      if (strict && started) chk("no_bubble", bus.out_valid, 1);
      if (bus.out_valid && bus.out_ready) begin
        started = 1'b1;
        chk("digit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("digit", bus.out_digit, e[3:0]);
          chk("last", bus.out_last, e[4]);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) void'(in_q.pop_front());
      cyc++;
    end
    chk("engine_budget", (in_q.size() == 0 && exp_q.size() == 0), 1);
    idle();
    tick();
    chk("idle_after", bus.out_valid, 0);
  endtask

  initial begin
    logic [9:0]  dv [4];
    logic [11:0] dg;
    int          accepted;
    int          nd;
    logic        flz;

    for (int i = 0; i < 1024; i++) ref_tab[i] = 12'h000;
    for (int n = 0; n < 1000; n++) begin
      ref_tab[ref_encode(4'(n / 100), 4'((n / 10) % 10), 4'(n % 10))] =
        {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    end

    // Reset
    idle();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_digit", bus.out_digit, 0);
    chk("reset_out_last", bus.out_last, 0);
    chk("reset_in_ready", bus.in_ready, 1);

    // 1: 999, latency of two cycles after accept
    bus.out_ready = 1'b1;
    push_one(10'h3FF, 1'b1, 1'b0);
    chk("t1_lat_c1", bus.out_valid, 0);
    tick();
    chk("t1_valid0", bus.out_valid, 1);
    chk("t1_digit0", bus.out_digit, 9);
    chk("t1_last0", bus.out_last, 0);
    tick();
    chk("t1_digit1", bus.out_digit, 9);
    chk("t1_last1", bus.out_last, 0);
    tick();
    chk("t1_digit2", bus.out_digit, 9);
    chk("t1_last2", bus.out_last, 1);
    tick();
    chk("t1_done", bus.out_valid, 0);

    // 2: 097 with lz -> bubble then 9,7; without lz -> 0,9,7
    push_one(10'h07B, 1'b1, 1'b1);
    chk("t2_lat_c1", bus.out_valid, 0);
    tick();
    chk("t2_bubble", bus.out_valid, 0);
    tick();
    chk("t2_valid_a", bus.out_valid, 1);
    chk("t2_digit_a", bus.out_digit, 9);
    chk("t2_last_a", bus.out_last, 0);
    tick();
    chk("t2_digit_b", bus.out_digit, 7);
    chk("t2_last_b", bus.out_last, 1);
    tick();
    chk("t2_done", bus.out_valid, 0);
    add_declet(10'h07B, 1'b1, 1'b0);
    run_engine(100, 100, 1'b1, 50);

    // 3: all-zero lz frame yields a single 0; next frame has lead restored
    add_declet(10'h000, 1'b0, 1'b1);
    add_declet(10'h000, 1'b1, 1'b1);
    add_declet(10'h001, 1'b1, 1'b1);
    run_engine(70, 70, 1'b0, 200);

    // 4: back-pressure fills FIFO plus stage, digit holds stable
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv[i] = 10'($urandom_range(1023));
      add_declet(dv[i], (i == 3), 1'b0);
    end
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (in_q.size() > 0);
      if (in_q.size() > 0) {bus.in_lz, bus.in_last, bus.in_declet} = in_q[0];
      if (bus.out_valid) chk("t4_hold_digit", bus.out_digit, exp_q[0][3:0]);
      if (bus.in_valid && bus.in_ready) begin
        tick();
        void'(in_q.pop_front());
        accepted++;
      end else begin
        tick();
      end
    end
    idle();
    chk("t4_accepted", accepted, 3);
    chk("t4_in_ready_full", bus.in_ready, 0);
    chk("t4_valid_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_rel_valid", bus.out_valid, 1);
      chk("t4_rel_digit", bus.out_digit, exp_q[0][3:0]);
      chk("t4_rel_last", bus.out_last, exp_q[0][4]);
      void'(exp_q.pop_front());
      tick();
      chk("t4_in_ready_rel", bus.in_ready, (k == 2));
    end
    run_engine(100, 100, 1'b0, 100);

    // 5: reset mid-frame discards everything and restores lead
    dv[0] = 10'($urandom_range(1023));
    dv[1] = 10'($urandom_range(1023));
    dg = ref_digits(dv[0]);
    bus.out_ready = 1'b1;
    push_one(dv[0], 1'b0, 1'b0);
    push_one(dv[1], 1'b1, 1'b0);
    chk("t5_first_valid", bus.out_valid, 1);
    chk("t5_first_digit", bus.out_digit, dg[11:8]);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_in_ready", bus.in_ready, 1);
    chk("t5_rst_last", bus.out_last, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_stale", bus.out_valid, 0);
    end
    add_declet(10'h000, 1'b0, 1'b1);
    add_declet(10'h005, 1'b1, 1'b1);
    run_engine(100, 100, 1'b0, 100);

    // 6: every declet code, lz off, continuous flow
    for (int n = 0; n < 1024; n++) begin
      add_declet(10'(n), (n == 1023) || ($urandom_range(3) == 0), 1'b0);
    end
    run_engine(100, 100, 1'b1, 5000);

    // 7: random frames, random lz, random handshakes
    for (int f = 0; f < 40; f++) begin
      nd  = int'($urandom_range(3, 1));
      flz = 1'($urandom_range(1));
      for (int j = 0; j < nd; j++) begin
        case ($urandom_range(2))
          0:       dv[0] = 10'h000;
          1:       dv[0] = 10'($urandom_range(15));
          default: dv[0] = 10'($urandom_range(1023));
        endcase
        add_declet(dv[0], (j == nd - 1), flz);
      end
    end
    run_engine(60, 60, 1'b0, 5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
